booth_op_seq: RTL and testbench
===============================

BOOTH_OP_SEQ -- requirements
Module: booth_op_seq

Interface
REQ-001 Parameter: TIMEOUT, default 15, maximum RUN-state cycles allowed before mul_done must be seen.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 in_valid  in  1  operand pair offered.
REQ-005 in_ready  out  1  block can accept an operand pair.
REQ-006 in_a, in_b  in  4 each  signed two's-complement operands.
REQ-007 acc_clr  in  1  synchronous clear of the running accumulator.
REQ-008 mul_en  out  1  enable to the 4-bit Booth multiplier; low clears it.
REQ-009 mul_a, mul_b  out  4 each  operands driven to the multiplier.
REQ-010 mul_prod  in  8  signed product from the multiplier.
REQ-011 mul_done  in  1  multiplier completion flag; stays high while enabled.
REQ-012 out_valid  out  1  result available.
REQ-013 out_ready  in  1  consumer accepts the result.
REQ-014 out_prod  out  8  captured signed product.
REQ-015 out_acc  out  12  signed running sum of accepted products.
REQ-016 err  out  1  sticky timeout flag.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and HOLD; all outputs registered.
REQ-019 IDLE: in_ready=1, mul_en=0; on in_valid&in_ready, latch in_a/in_b into mul_a/mul_b, clear run counter, go to RUN.
REQ-020 RUN: mul_en=1, mul_a/mul_b stable; run counter increments each cycle.
REQ-021 mul_done SHALL be ignored in the first RUN cycle (counter=0); it is sampled only when the counter is at least 1.
REQ-022 RUN, valid mul_done=1: capture mul_prod into out_prod, add sign-extended mul_prod to out_acc, set out_valid=1, mul_en=0, go to HOLD.
REQ-023 RUN, counter reaches TIMEOUT with no mul_done: set err=1, mul_en=0, leave out_prod/out_acc unchanged, out_valid stays 0, go to IDLE.
REQ-024 HOLD: out_valid=1, mul_en=0, in_ready=0; on out_valid&out_ready clear out_valid, go to IDLE.
REQ-025 mul_en SHALL be low for at least one full cycle between consecutive operations.
REQ-026 Latency from accept edge to out_valid=1 SHALL be the multiplier done latency plus one cycle; 7 cycles with the 4-bit Booth multiplier.
REQ-027 Throughput SHALL be at most one operation per (latency + 2) cycles with out_ready held high.
REQ-028 out_acc arithmetic SHALL be signed 12-bit, wrapping modulo 2^12 without saturation.
REQ-029 acc_clr alone: out_acc=0 next cycle.
REQ-030 acc_clr in the same cycle as a capture: out_acc = sign-extended product (clear applied before add).
REQ-031 out_prod and out_acc SHALL hold their values until the next capture, clear or reset.
REQ-032 in_valid while not in IDLE SHALL be ignored (in_ready=0); no buffering.
REQ-033 err SHALL remain set until rst; it does not block further operations.

Reset
REQ-034 rst=1 at a clock edge SHALL force IDLE, mul_en=0, mul_a=mul_b=0, out_valid=0, out_prod=0, out_acc=0, err=0, counter=0, busy=0.
REQ-035 rst SHALL take priority over every other input, including mid-RUN and mid-HOLD; the result in flight is discarded.

Verification
REQ-036 Reset, then accept a=1110, b=1110 -> out_valid after 7 cycles, out_prod=0x04, out_acc=0x004.
REQ-037 Then a=1011, b=0010, then a=0111, b=0010 -> out_prod=0xF6, out_acc=0xFFA; then out_prod=0x0E, out_acc=0x008.
REQ-038 Hold out_ready=0 for 5 cycles in HOLD -> out_valid stays 1, mul_en=0, in_ready=0, outputs stable; release -> IDLE next cycle.
REQ-039 Tie mul_done=0 -> err=1 after TIMEOUT RUN cycles, mul_en=0, out_valid never asserted, next operand accepted normally.
REQ-040 acc_clr on capture cycle of a=1111, b=1111 -> out_acc=0x001; acc_clr alone -> out_acc=0x000.
REQ-041 Assert rst 3 cycles into RUN -> all outputs at reset values next cycle, no out_valid for that operation.

Source files
------------

// File: rtl/booth_op_seq.sv
// Operation sequencer around a 4-bit Booth multiplier: accepts one operand pair,
// runs the multiplier with a timeout, captures the product and keeps a wrapping 12-bit sum.
module booth_op_seq #(
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic signed [3:0] in_a,
  input  logic signed [3:0] in_b,
  input  logic              acc_clr,
  output logic              mul_en,
  output logic signed [3:0] mul_a,
  output logic signed [3:0] mul_b,
  input  logic signed [7:0] mul_prod,
  input  logic              mul_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic signed [7:0] out_prod,
  output logic signed [11:0] out_acc,
  output logic              err,
  output logic              busy
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               mul_en_q, mul_en_d;
  logic signed [3:0]  mul_a_q, mul_a_d;
  logic signed [3:0]  mul_b_q, mul_b_d;
  logic               out_valid_q, out_valid_d;
  logic signed [7:0]  prod_q, prod_d;
  logic signed [11:0] acc_q, acc_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;

  // Two's-complement add of the sign-extended product; wraps modulo 2^12.
  function automatic logic signed [11:0] acc_add(input logic signed [11:0] base,
                                                 input logic signed [7:0]  prod);
    acc_add = base + {{4{prod[7]}}, prod};
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    mul_en_d    = mul_en_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    out_valid_d = out_valid_q;
    prod_d      = prod_q;
    acc_d       = acc_clr ? 12'sd0 : acc_q;
    err_d       = err_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          mul_a_d    = in_a;
          mul_b_d    = in_b;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          mul_en_d   = 1'b1;
          busy_d     = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        // The first RUN cycle cannot carry a valid done, so it is masked.
        if (cnt_q != '0 && mul_done) begin
          prod_d      = mul_prod;
          acc_d       = acc_add(acc_d, mul_prod);
          out_valid_d = 1'b1;
          mul_en_d    = 1'b0;
          state_d     = HOLD;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d      = 1'b1;
          mul_en_d   = 1'b0;
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
          cnt_d      = '0;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        mul_en_d    = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      mul_en_q    <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      out_valid_q <= 1'b0;
      prod_q      <= '0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      mul_en_q    <= mul_en_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      out_valid_q <= out_valid_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mul_en    = mul_en_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_valid = out_valid_q;
  assign out_prod  = prod_q;
  assign out_acc   = acc_q;
  assign err       = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_booth_op_seq.sv
// Scoreboarded bench for booth_op_seq with a cycle-counting multiplier stand-in.
module tb_booth_op_seq;

  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic signed [3:0] in_a = '0;
  logic signed [3:0] in_b = '0;
  logic              acc_clr = 1'b0;
  logic              mul_en;
  logic signed [3:0] mul_a;
  logic signed [3:0] mul_b;
  logic signed [7:0] mul_prod;
  logic              mul_done;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic signed [7:0] out_prod;
  logic signed [11:0] out_acc;
  logic              err;
  logic              busy;

  booth_op_seq #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .acc_clr(acc_clr), .mul_en(mul_en),
    .mul_a(mul_a), .mul_b(mul_b), .mul_prod(mul_prod), .mul_done(mul_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod),
    .out_acc(out_acc), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: done rises six cycles after enable, product is plain signed multiply.
  logic       nodone = 1'b0;
  logic [3:0] mcnt = '0;
  always @(posedge clk) begin
    if (!mul_en) mcnt <= '0;
    else if (mcnt != 4'd15) mcnt <= mcnt + 4'd1;
  end
  assign mul_done = mul_en && (mcnt >= 4'd6) && !nodone;
  assign mul_prod = 8'(int'(mul_a) * int'(mul_b));

  typedef struct packed { logic [7:0] prod; logic [11:0] acc; } exp_t;
  exp_t       sb_q[$];
  logic [11:0] model_acc = '0;
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard pop per result presentation.
  logic seen = 1'b0;
  always @(negedge clk) begin
    if (rst) seen = 1'b0;
    else if (out_valid && !seen) begin
      seen = 1'b1;
      if (sb_q.size() == 0) check("out_valid_without_op", {31'd0, out_valid}, 32'd0);
      else begin
        exp_t e;
        e = sb_q.pop_front();
        check("out_prod", {24'd0, out_prod}, {24'd0, e.prod});
        check("out_acc", {20'd0, out_acc}, {20'd0, e.acc});
      end
    end else if (!out_valid) seen = 1'b0;
  end

  function automatic exp_t predict(input logic [3:0] a, input logic [3:0] b, input logic clr);
    int p;
    exp_t e;
    p = int'($signed(a)) * int'($signed(b));
    e.prod = 8'(p);
    e.acc  = 12'(p) + (clr ? 12'd0 : model_acc);
    return e;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic clr, input int hold);
    exp_t e;
    int lat;
    @(negedge clk);
    wait_ready();
    e = predict(a, b, clr);
    sb_q.push_back(e);
    model_acc = e.acc;
    in_a = a; in_b = b; in_valid = 1'b1; acc_clr = clr;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    acc_clr = 1'b0;
    check("latency", lat, 7);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_mul_en", {31'd0, mul_en}, 32'd0);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_prod", {24'd0, out_prod}, {24'd0, e.prod});
      check("hold_acc", {20'd0, out_acc}, {20'd0, e.acc});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_out_valid", {31'd0, out_valid}, 32'd0);
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    check("release_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_mul_en"}, {31'd0, mul_en}, 32'd0);
    check({tag, "_mul_ab"}, {24'd0, mul_a, mul_b}, 32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out_prod"}, {24'd0, out_prod}, 32'd0);
    check({tag, "_out_acc"}, {20'd0, out_acc}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 check_reset_state("reset");
    @(negedge clk); rst = 1'b0;

    do_op(4'b1110, 4'b1110, 1'b0, 5);
    do_op(4'b1011, 4'b0010, 1'b0, 0);
    do_op(4'b0111, 4'b0010, 1'b0, 1);
    do_op(4'b1111, 4'b1111, 1'b1, 0);

    // acc_clr on its own
    @(negedge clk); acc_clr = 1'b1;
    @(posedge clk); #1 acc_clr = 1'b0;
    model_acc = '0;
    check("acc_clr_alone", {20'd0, out_acc}, 32'd0);
    do_op(4'b0011, 4'b1101, 1'b0, 0);

    // Timeout with done never arriving
    nodone = 1'b1;
    @(negedge clk);
    wait_ready();
    in_a = 4'd5; in_b = 4'd3; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    n = 0;
    while (!err && n < 40) begin @(posedge clk); #1; n++; end
    check("timeout_cycles", n, TIMEOUT);
    check("timeout_mul_en", {31'd0, mul_en}, 32'd0);
    check("timeout_busy", {31'd0, busy}, 32'd0);
    check("timeout_acc_kept", {20'd0, out_acc}, {20'd0, model_acc});
    nodone = 1'b0;
    do_op(4'b0110, 4'b1001, 1'b0, 0);
    check("err_sticky", {31'd0, err}, 32'd1);

    // Reset three cycles into RUN
    @(negedge clk);
    wait_ready();
    in_a = 4'd7; in_b = 4'd7; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1 check_reset_state("midrun_reset");
    @(negedge clk); rst = 1'b0;
    model_acc = '0;
    repeat (12) @(negedge clk);

    for (int k = 0; k < 20; k++) begin
      do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
